// File: rtl/execute_if.sv
// Bundle of the execute stage's decode-side inputs, writeback forward path and E/M outputs.
// The master modport is the decode/hazard side; execute_stage connects through the slave modport.
interface execute_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CONTROL_WIDTH  = 4
);
  // Pipeline control: FlushE_i beats hold. While StallE_i or BusyE_o is high the E instruction
  // stays put and E/M receives a bubble; otherwise one instruction advances per clock edge.
  logic                      StallE_i;
  logic                      FlushE_i;
  logic                      RegWriteD_i;
  logic [1:0]                ResultSrcD_i;
  logic                      MemWriteD_i;
  logic                      JumpD_i;
  logic                      BranchD_i;
  logic [2:0]                BranchTypeD_i;
  logic [CONTROL_WIDTH-1:0]  ALUControlD_i;
  logic                      ALUSrcD_i;
  logic [DATA_WIDTH-1:0]     RD1D_i;
  logic [DATA_WIDTH-1:0]     RD2D_i;
  logic [DATA_WIDTH-1:0]     PCD_i;
  logic [DATA_WIDTH-1:0]     PCPlus4D_i;
  logic [DATA_WIDTH-1:0]     ExtImmD_i;
  logic [REG_ADDR_WIDTH-1:0] Rs1D_i;
  logic [REG_ADDR_WIDTH-1:0] Rs2D_i;
  logic [REG_ADDR_WIDTH-1:0] RdD_i;
  logic [DATA_WIDTH-1:0]     ResultW_i;
  logic [REG_ADDR_WIDTH-1:0] RdW_i;
  logic                      RegWriteW_i;

  logic                      PCSrcE_o;
  logic [DATA_WIDTH-1:0]     PCTargetE_o;
  logic                      BusyE_o;
  logic [REG_ADDR_WIDTH-1:0] Rs1E_o;
  logic [REG_ADDR_WIDTH-1:0] Rs2E_o;
  logic [REG_ADDR_WIDTH-1:0] RdE_o;
  logic                      RegWriteM_o;
  logic                      MemWriteM_o;
  logic [1:0]                ResultSrcM_o;
  logic [REG_ADDR_WIDTH-1:0] RdM_o;
  logic [DATA_WIDTH-1:0]     ALUResultM_o;
  logic [DATA_WIDTH-1:0]     WriteDataM_o;
  logic [DATA_WIDTH-1:0]     PCPlus4M_o;
  logic [1:0]                MulStateE_o;

  modport master (
    output StallE_i, FlushE_i, RegWriteD_i, ResultSrcD_i, MemWriteD_i, JumpD_i, BranchD_i,
           BranchTypeD_i, ALUControlD_i, ALUSrcD_i, RD1D_i, RD2D_i, PCD_i, PCPlus4D_i, ExtImmD_i,
           Rs1D_i, Rs2D_i, RdD_i, ResultW_i, RdW_i, RegWriteW_i,
    input  PCSrcE_o, PCTargetE_o, BusyE_o, Rs1E_o, Rs2E_o, RdE_o, RegWriteM_o, MemWriteM_o,
           ResultSrcM_o, RdM_o, ALUResultM_o, WriteDataM_o, PCPlus4M_o, MulStateE_o
  );

  modport slave (
    input  StallE_i, FlushE_i, RegWriteD_i, ResultSrcD_i, MemWriteD_i, JumpD_i, BranchD_i,
           BranchTypeD_i, ALUControlD_i, ALUSrcD_i, RD1D_i, RD2D_i, PCD_i, PCPlus4D_i, ExtImmD_i,
           Rs1D_i, Rs2D_i, RdD_i, ResultW_i, RdW_i, RegWriteW_i,
    output PCSrcE_o, PCTargetE_o, BusyE_o, Rs1E_o, Rs2E_o, RdE_o, RegWriteM_o, MemWriteM_o,
           ResultSrcM_o, RdM_o, ALUResultM_o, WriteDataM_o, PCPlus4M_o, MulStateE_o
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: D/E register, M/W forwarding, ALU, branch resolution and E/M register.
// Define MUL_EN to build the radix-2 shift-add multiplier for ALU code 10 (otherwise it yields 0).
module execute_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CONTROL_WIDTH  = 4
) (
  input logic       clk,
  input logic       rst_n,
  execute_if.slave  bus
);
  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  localparam logic [CONTROL_WIDTH-1:0] ALU_ADD  = CONTROL_WIDTH'(0);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SUB  = CONTROL_WIDTH'(1);
  localparam logic [CONTROL_WIDTH-1:0] ALU_AND  = CONTROL_WIDTH'(2);
  localparam logic [CONTROL_WIDTH-1:0] ALU_OR   = CONTROL_WIDTH'(3);
  localparam logic [CONTROL_WIDTH-1:0] ALU_XOR  = CONTROL_WIDTH'(4);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SLT  = CONTROL_WIDTH'(5);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SLTU = CONTROL_WIDTH'(6);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SLL  = CONTROL_WIDTH'(7);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SRL  = CONTROL_WIDTH'(8);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SRA  = CONTROL_WIDTH'(9);
  localparam logic [CONTROL_WIDTH-1:0] ALU_MUL  = CONTROL_WIDTH'(10);

  typedef struct packed {
    logic                      regWrite;
    logic [1:0]                resultSrc;
    logic                      memWrite;
    logic                      jump;
    logic                      branch;
    logic [2:0]                branchType;
    logic [CONTROL_WIDTH-1:0]  aluControl;
    logic                      aluSrc;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     pcPlus4;
    logic [DATA_WIDTH-1:0]     extImm;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } deReg_t;

  typedef struct packed {
    logic                      regWrite;
    logic                      memWrite;
    logic [1:0]                resultSrc;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     aluResult;
    logic [DATA_WIDTH-1:0]     writeData;
    logic [DATA_WIDTH-1:0]     pcPlus4;
  } emReg_t;

  deReg_t                de, deNext;
  emReg_t                em, emNext;
  logic [DATA_WIDTH-1:0] srcA, fwdB, srcB, aluResult, mulResult;
  logic [SHAMT_W-1:0]    shamt;
  logic                  busyE, mulAbort, branchCond;

  assign deNext = '{regWrite: bus.RegWriteD_i, resultSrc: bus.ResultSrcD_i,
                    memWrite: bus.MemWriteD_i, jump: bus.JumpD_i, branch: bus.BranchD_i,
                    branchType: bus.BranchTypeD_i, aluControl: bus.ALUControlD_i,
                    aluSrc: bus.ALUSrcD_i, rd1: bus.RD1D_i, rd2: bus.RD2D_i, pc: bus.PCD_i,
                    pcPlus4: bus.PCPlus4D_i, extImm: bus.ExtImmD_i, rs1: bus.Rs1D_i,
                    rs2: bus.Rs2D_i, rd: bus.RdD_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        de <= '0;
    else if (bus.FlushE_i)             de <= '0;
    else if (!(bus.StallE_i || busyE)) de <= deNext;
  end

  // M beats W on a match; x0 is hardwired and never forwarded.
  always_comb begin
    srcA = de.rd1;
    if (em.regWrite && em.rd != '0 && em.rd == de.rs1)           srcA = em.aluResult;
    else if (bus.RegWriteW_i && bus.RdW_i != '0 && bus.RdW_i == de.rs1) srcA = bus.ResultW_i;
    fwdB = de.rd2;
    if (em.regWrite && em.rd != '0 && em.rd == de.rs2)           fwdB = em.aluResult;
    else if (bus.RegWriteW_i && bus.RdW_i != '0 && bus.RdW_i == de.rs2) fwdB = bus.ResultW_i;
  end

  assign srcB  = de.aluSrc ? de.extImm : fwdB;
  assign shamt = srcB[SHAMT_W-1:0];

  always_comb begin
    aluResult = '0;
    case (de.aluControl)
      ALU_ADD:  aluResult = srcA + srcB;
      ALU_SUB:  aluResult = srcA - srcB;
      ALU_AND:  aluResult = srcA & srcB;
      ALU_OR:   aluResult = srcA | srcB;
      ALU_XOR:  aluResult = srcA ^ srcB;
      ALU_SLT:  aluResult[0] = $signed(srcA) < $signed(srcB);
      ALU_SLTU: aluResult[0] = srcA < srcB;
      ALU_SLL:  aluResult = srcA << shamt;
      ALU_SRL:  aluResult = srcA >> shamt;
      ALU_SRA:  aluResult = $signed(srcA) >>> shamt;
      ALU_MUL:  aluResult = mulResult;
      default:  aluResult = '0;
    endcase
  end

  always_comb begin
    branchCond = 1'b0;
    case (de.branchType)
      3'b000:  branchCond = srcA == fwdB;
      3'b001:  branchCond = srcA != fwdB;
      3'b100:  branchCond = $signed(srcA) < $signed(fwdB);
      3'b101:  branchCond = !($signed(srcA) < $signed(fwdB));
      3'b110:  branchCond = srcA < fwdB;
      3'b111:  branchCond = !(srcA < fwdB);
      default: branchCond = 1'b0;
    endcase
  end

`ifdef MUL_EN
  typedef enum logic [1:0] {MUL_IDLE = 2'd0, MUL_RUN = 2'd1, MUL_DONE = 2'd2} mulState_t;
  mulState_t             mulState, mulStateNext;
  logic [DATA_WIDTH-1:0] mulA, mulB, mulAcc;
  logic [SHAMT_W-1:0]    mulCnt;
  logic                  mulStart;

  // The entry cycle performs the first shift-add step, so IDLE-entry plus RUN spans DATA_WIDTH cycles.
  assign mulStart = (mulState == MUL_IDLE) && (de.aluControl == ALU_MUL) && !bus.FlushE_i;

  always_comb begin
    mulStateNext = mulState;
    case (mulState)
      MUL_IDLE: if (mulStart) mulStateNext = MUL_RUN;
      MUL_RUN:  if (bus.FlushE_i) mulStateNext = MUL_IDLE;
                else if (mulCnt == SHAMT_W'(1)) mulStateNext = MUL_DONE;
      MUL_DONE: if (bus.FlushE_i || !bus.StallE_i) mulStateNext = MUL_IDLE;
      default:  mulStateNext = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mulState <= MUL_IDLE;
      mulA     <= '0;
      mulB     <= '0;
      mulAcc   <= '0;
      mulCnt   <= '0;
    end else begin
      mulState <= mulStateNext;
      if (mulStart) begin
        mulAcc <= srcB[0] ? srcA : '0;
        mulA   <= srcA << 1;
        mulB   <= srcB >> 1;
        mulCnt <= SHAMT_W'(DATA_WIDTH - 1);
      end else if (mulState == MUL_RUN) begin
        mulAcc <= mulAcc + (mulB[0] ? mulA : '0);
        mulA   <= mulA << 1;
        mulB   <= mulB >> 1;
        mulCnt <= mulCnt - SHAMT_W'(1);
      end
    end
  end

  assign busyE           = mulStart || (mulState == MUL_RUN);
  assign mulAbort        = (mulState == MUL_DONE) && bus.FlushE_i;
  assign mulResult       = mulAcc;
  assign bus.MulStateE_o = mulState;
`else
  assign busyE           = 1'b0;
  assign mulAbort        = 1'b0;
  assign mulResult       = '0;
  assign bus.MulStateE_o = 2'd0;
`endif

  assign emNext = '{regWrite: de.regWrite, memWrite: de.memWrite, resultSrc: de.resultSrc,
                    rd: de.rd, aluResult: aluResult, writeData: fwdB, pcPlus4: de.pcPlus4};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   em <= '0;
    else if (bus.StallE_i || busyE || mulAbort)   em <= '0;
    else                                          em <= emNext;
  end

  assign bus.PCSrcE_o     = de.jump | (de.branch & branchCond);
  assign bus.PCTargetE_o  = de.pc + de.extImm;
  assign bus.BusyE_o      = busyE;
  assign bus.Rs1E_o       = de.rs1;
  assign bus.Rs2E_o       = de.rs2;
  assign bus.RdE_o        = de.rd;
  assign bus.RegWriteM_o  = em.regWrite;
  assign bus.MemWriteM_o  = em.memWrite;
  assign bus.ResultSrcM_o = em.resultSrc;
  assign bus.RdM_o        = em.rd;
  assign bus.ALUResultM_o = em.aluResult;
  assign bus.WriteDataM_o = em.writeData;
  assign bus.PCPlus4M_o   = em.pcPlus4;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU ops, forwarding, branches, stall/flush, reset, multiplier.
module tb_execute_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   nChecks = 0;
  int   nFails  = 0;
  int   busyCnt;
  logic [DW-1:0] expQ[$];

  execute_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CONTROL_WIDTH(CW)) bus();

  execute_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CONTROL_WIDTH(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] expVal);
    nChecks++;
    if (act !== expVal) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, expVal);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearD();
    bus.RegWriteD_i   = 1'b0;
    bus.ResultSrcD_i  = 2'b00;
    bus.MemWriteD_i   = 1'b0;
    bus.JumpD_i       = 1'b0;
    bus.BranchD_i     = 1'b0;
    bus.BranchTypeD_i = 3'b000;
    bus.ALUControlD_i = '0;
    bus.ALUSrcD_i     = 1'b0;
    bus.RD1D_i        = '0;
    bus.RD2D_i        = '0;
    bus.PCD_i         = '0;
    bus.PCPlus4D_i    = '0;
    bus.ExtImmD_i     = '0;
    bus.Rs1D_i        = '0;
    bus.Rs2D_i        = '0;
    bus.RdD_i         = '0;
  endtask

  task automatic setW(input logic en, input logic [AW-1:0] rd, input logic [DW-1:0] val);
    bus.RegWriteW_i = en;
    bus.RdW_i       = rd;
    bus.ResultW_i   = val;
  endtask

  // Drive one instruction into D, clock it into E, and score whatever reached M.
  task automatic issue(input string tag, input logic [CW-1:0] ctrl, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic [AW-1:0] rd, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic src, input logic [DW-1:0] imm,
                       input logic regWr, input logic [DW-1:0] expRes);
    logic [DW-1:0] e;
    clearD();
    bus.ALUControlD_i = ctrl;
    bus.Rs1D_i        = rs1;
    bus.Rs2D_i        = rs2;
    bus.RdD_i         = rd;
    bus.RD1D_i        = a;
    bus.RD2D_i        = b;
    bus.ALUSrcD_i     = src;
    bus.ExtImmD_i     = imm;
    bus.RegWriteD_i   = regWr;
    expQ.push_back(expRes);
    tick();
    if (expQ.size() > 1) begin
      e = expQ.pop_front();
      checkEq(tag, bus.ALUResultM_o, e);
    end
  endtask

  task automatic drain();
    logic [DW-1:0] e;
    while (expQ.size() > 0) begin
      clearD();
      tick();
      e = expQ.pop_front();
      checkEq("drain", bus.ALUResultM_o, e);
    end
  endtask

  task automatic branchCheck(input string tag, input logic jmp, input logic br,
                             input logic [2:0] bt, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic expTaken);
    clearD();
    bus.JumpD_i       = jmp;
    bus.BranchD_i     = br;
    bus.BranchTypeD_i = bt;
    bus.RD1D_i        = a;
    bus.RD2D_i        = b;
    bus.PCD_i         = 32'h0000_0100;
    bus.ExtImmD_i     = 32'h0000_0020;
    tick();
    checkEq(tag, {31'd0, bus.PCSrcE_o}, {31'd0, expTaken});
    checkEq({tag, "_target"}, bus.PCTargetE_o, 32'h0000_0120);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkEq({tag, "_regwrite_m"}, {31'd0, bus.RegWriteM_o}, 32'd0);
    checkEq({tag, "_memwrite_m"}, {31'd0, bus.MemWriteM_o}, 32'd0);
    checkEq({tag, "_aluresult_m"}, bus.ALUResultM_o, 32'd0);
    checkEq({tag, "_rd_m"}, {27'd0, bus.RdM_o}, 32'd0);
    checkEq({tag, "_pcsrc"}, {31'd0, bus.PCSrcE_o}, 32'd0);
    checkEq({tag, "_pctarget"}, bus.PCTargetE_o, 32'd0);
    checkEq({tag, "_busy"}, {31'd0, bus.BusyE_o}, 32'd0);
    checkEq({tag, "_rs1_e"}, {27'd0, bus.Rs1E_o}, 32'd0);
    checkEq({tag, "_mulstate"}, {30'd0, bus.MulStateE_o}, 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.StallE_i = 1'b0;
    bus.FlushE_i = 1'b0;
    clearD();
    setW(1'b0, '0, '0);
    #3;
    checkResetOutputs("reset");
    #2 rst_n = 1'b1;

    // ADD 5+7, then the ALU op table; operands come straight from RD1/RD2 (rs = x0)
    issue("add_5_7", 4'd0, 5'd0, 5'd0, 5'd3, 32'd5, 32'd7, 1'b0, 32'd0, 1'b1, 32'd12);
    issue("add_result", 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkEq("add_rd_m", {27'd0, bus.RdM_o}, 32'd3);
    checkEq("add_regwrite_m", {31'd0, bus.RegWriteM_o}, 32'd1);
    issue("sub", 4'd1, 5'd0, 5'd0, 5'd0, 32'd5, 32'd7, 1'b0, 32'd0, 1'b0, 32'hFFFF_FFFE);
    issue("and", 4'd2, 5'd0, 5'd0, 5'd0, 32'hF0F0, 32'hFF00, 1'b0, 32'd0, 1'b0, 32'hF000);
    issue("or", 4'd3, 5'd0, 5'd0, 5'd0, 32'hF0F0, 32'h0F00, 1'b0, 32'd0, 1'b0, 32'hFFF0);
    issue("xor", 4'd4, 5'd0, 5'd0, 5'd0, 32'hFF, 32'h0F, 1'b0, 32'd0, 1'b0, 32'hF0);
    issue("slt", 4'd5, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b0, 32'd1);
    issue("sltu", 4'd6, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b0, 32'd0);
    issue("sll_imm", 4'd7, 5'd0, 5'd0, 5'd0, 32'd1, 32'd0, 1'b1, 32'h24, 1'b0, 32'd16);
    issue("srl", 4'd8, 5'd0, 5'd0, 5'd0, 32'h8000_0000, 32'd4, 1'b0, 32'd0, 1'b0, 32'h0800_0000);
    issue("sra", 4'd9, 5'd0, 5'd0, 5'd0, 32'h8000_0000, 32'd4, 1'b0, 32'd0, 1'b0, 32'hF800_0000);
    issue("code15", 4'd15, 5'd0, 5'd0, 5'd0, 32'd3, 32'd4, 1'b0, 32'd0, 1'b0, 32'd0);
`ifndef MUL_EN
    issue("mul_disabled", 4'd10, 5'd0, 5'd0, 5'd0, 32'd6, 32'd7, 1'b0, 32'd0, 1'b0, 32'd0);
    checkEq("mul_disabled_busy", {31'd0, bus.BusyE_o}, 32'd0);
`endif
    drain();

    // Forwarding: A writes x1=3 (M), W offers x1=9; B sees M, C sees W, x0 never forwarded
    issue("fwd_a", 4'd0, 5'd0, 5'd0, 5'd1, 32'd1, 32'd2, 1'b0, 32'd0, 1'b1, 32'd3);
    issue("fwd_b", 4'd0, 5'd1, 5'd0, 5'd5, 32'd100, 32'd0, 1'b0, 32'd0, 1'b1, 32'd3);
    setW(1'b1, 5'd1, 32'd9);
    issue("fwd_m_wins", 4'd0, 5'd1, 5'd0, 5'd4, 32'd100, 32'd0, 1'b0, 32'd0, 1'b1, 32'd9);
    issue("fwd_w_only", 4'd0, 5'd0, 5'd0, 5'd0, 32'd50, 32'd0, 1'b0, 32'd0, 1'b1, 32'd50);
    setW(1'b0, '0, '0);
    issue("fwd_x0_w", 4'd0, 5'd0, 5'd2, 5'd4, 32'd100, 32'd5, 1'b0, 32'd0, 1'b1, 32'd105);
    setW(1'b1, 5'd0, 32'd9);
    issue("fwd_x0_m", 4'd1, 5'd0, 5'd4, 5'd6, 32'd200, 32'd7, 1'b0, 32'd0, 1'b1, 32'd95);
    setW(1'b0, '0, '0);
    issue("fwd_rs2_m", 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkEq("fwd_writedata", bus.WriteDataM_o, 32'd105);
    drain();

    // Branch / jump resolution with PCE=0x100, imm=0x20
    branchCheck("blt_taken", 1'b0, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1);
    branchCheck("bltu_not", 1'b0, 1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0);
    branchCheck("bge_not", 1'b0, 1'b1, 3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0);
    branchCheck("bgeu_taken", 1'b0, 1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1);
    branchCheck("beq_taken", 1'b0, 1'b1, 3'b000, 32'd5, 32'd5, 1'b1);
    branchCheck("bne_not", 1'b0, 1'b1, 3'b001, 32'd5, 32'd5, 1'b0);
    branchCheck("type010_not", 1'b0, 1'b1, 3'b010, 32'd5, 32'd5, 1'b0);
    branchCheck("jump", 1'b1, 1'b0, 3'b000, 32'd1, 32'd2, 1'b1);
    branchCheck("no_branch_flag", 1'b0, 1'b0, 3'b000, 32'd5, 32'd5, 1'b0);
    clearD();
    tick();

    // Stall for two cycles: P held in E, two bubbles into M, then P and Q drain in order
    clearD();
    bus.RegWriteD_i = 1'b1; bus.Rs1D_i = 5'd11; bus.RdD_i = 5'd8;
    bus.RD1D_i = 32'd10; bus.RD2D_i = 32'd1;
    tick();
    bus.Rs1D_i = 5'd12; bus.RdD_i = 5'd9; bus.RD1D_i = 32'd20; bus.RD2D_i = 32'd2;
    bus.StallE_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkEq("stall_bubble_m", {31'd0, bus.RegWriteM_o}, 32'd0);
      checkEq("stall_hold_rs1e", {27'd0, bus.Rs1E_o}, 32'd11);
    end
    bus.StallE_i = 1'b0;
    tick();
    checkEq("stall_p_result", bus.ALUResultM_o, 32'd11);
    checkEq("stall_p_rd", {27'd0, bus.RdM_o}, 32'd8);
    checkEq("stall_q_in_e", {27'd0, bus.Rs1E_o}, 32'd12);
    clearD();
    tick();
    checkEq("stall_q_result", bus.ALUResultM_o, 32'd22);
    checkEq("stall_q_rd", {27'd0, bus.RdM_o}, 32'd9);

    // Flush together with stall loads a bubble
    bus.RegWriteD_i = 1'b1; bus.Rs1D_i = 5'd13; bus.RdD_i = 5'd10;
    bus.RD1D_i = 32'd1; bus.RD2D_i = 32'd1;
    bus.FlushE_i = 1'b1; bus.StallE_i = 1'b1;
    tick();
    checkEq("flush_rs1e", {27'd0, bus.Rs1E_o}, 32'd0);
    checkEq("flush_rde", {27'd0, bus.RdE_o}, 32'd0);
    bus.FlushE_i = 1'b0; bus.StallE_i = 1'b0;
    clearD();
    tick();
    checkEq("flush_regwrite_m", {31'd0, bus.RegWriteM_o}, 32'd0);
    checkEq("flush_rd_m", {27'd0, bus.RdM_o}, 32'd0);

`ifdef MUL_EN
    // 6*7: busy for DATA_WIDTH cycles, then 42 lands in M
    clearD();
    bus.ALUControlD_i = 4'd10; bus.RegWriteD_i = 1'b1; bus.RdD_i = 5'd12;
    bus.RD1D_i = 32'd6; bus.RD2D_i = 32'd7;
    tick();
    clearD();
    busyCnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.BusyE_o) break;
      busyCnt++;
      tick();
    end
    checkEq("mul_busy_cycles", busyCnt, 32'd32);
    tick();
    checkEq("mul_6x7", bus.ALUResultM_o, 32'd42);
    checkEq("mul_rd_m", {27'd0, bus.RdM_o}, 32'd12);

    bus.ALUControlD_i = 4'd10; bus.RegWriteD_i = 1'b1; bus.RdD_i = 5'd13;
    bus.RD1D_i = 32'hFFFF_FFFF; bus.RD2D_i = 32'd2;
    tick();
    clearD();
    for (int i = 0; i < 200; i++) begin
      if (!bus.BusyE_o) break;
      tick();
    end
    tick();
    checkEq("mul_wrap", bus.ALUResultM_o, 32'hFFFF_FFFE);

    // Flush mid-multiply aborts with no result
    bus.ALUControlD_i = 4'd10; bus.RegWriteD_i = 1'b1; bus.RdD_i = 5'd14;
    bus.RD1D_i = 32'd3; bus.RD2D_i = 32'd3;
    tick();
    clearD();
    tick(); tick(); tick();
    bus.FlushE_i = 1'b1;
    tick();
    bus.FlushE_i = 1'b0;
    checkEq("mul_flush_busy", {31'd0, bus.BusyE_o}, 32'd0);
    checkEq("mul_flush_regwrite", {31'd0, bus.RegWriteM_o}, 32'd0);
    tick();
    checkEq("mul_flush_no_result", {31'd0, bus.RegWriteM_o}, 32'd0);

    // Reset while the multiplier runs
    bus.ALUControlD_i = 4'd10; bus.RegWriteD_i = 1'b1; bus.RdD_i = 5'd15;
    bus.RD1D_i = 32'd5; bus.RD2D_i = 32'd5;
    tick();
    clearD();
    for (int i = 0; i < 5; i++) tick();
    checkEq("mul_running", {31'd0, bus.BusyE_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs("mul_reset");
    #1 rst_n = 1'b1;
    tick();
`endif

    // Reset mid-stream with a live instruction in M
    issue("pre_reset", 4'd0, 5'd0, 5'd0, 5'd7, 32'd1, 32'd1, 1'b0, 32'd0, 1'b1, 32'd2);
    issue("pre_reset_m", 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs("stream_reset");
    expQ.delete();
    #1 rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
